// File: rtl/cnn_pkg.sv
// Shared constants and the sequencer state type for the convolution engine.
package cnn_pkg;

   localparam int DATA_W      = 16;
   localparam int KERNEL_SIZE = 9;
   localparam int KDIM        = 3;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } seq_state_e;

endpackage

// File: rtl/conv_pe_seq_if.sv
// Result stream leaving the convolution sequencer: valid/ready with value and output-map index.
interface conv_pe_seq_if #(
   parameter int ADDR_W = 10
) ();

   logic                              out_valid;
   logic                              out_ready;
   logic signed [cnn_pkg::DATA_W-1:0] out_data;
   logic        [ADDR_W-1:0]          out_addr;

   modport master (output out_valid, output out_data, output out_addr, input out_ready);
   modport slave  (input out_valid, input out_data, input out_addr, output out_ready);

endinterface

// File: rtl/conv_out_fifo.sv
// Two-entry result buffer holding a PE result together with its output-map index.
module conv_out_fifo
   import cnn_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic signed [DATA_W-1:0] push_data,
   input  logic        [ADDR_W-1:0] push_addr,
   input  logic                     pop,
   output logic                     valid,
   output logic        [1:0]        count,
   output logic signed [DATA_W-1:0] head_data,
   output logic        [ADDR_W-1:0] head_addr
);

   logic signed [DATA_W-1:0] data_q [2];
   logic signed [DATA_W-1:0] data_d [2];
   logic        [ADDR_W-1:0] addr_q [2];
   logic        [ADDR_W-1:0] addr_d [2];
   logic                     wr_ptr_q, wr_ptr_d;
   logic                     rd_ptr_q, rd_ptr_d;
   logic        [1:0]        count_q, count_d;
   logic                     do_push, do_pop;

   // A push into a full buffer is still taken when the head leaves in the same cycle.
   always_comb begin
      do_pop   = pop && (count_q != 2'd0);
      do_push  = push && ((count_q != 2'd2) || do_pop);
      data_d   = data_q;
      addr_d   = addr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         data_d[wr_ptr_q] = push_data;
         addr_d[wr_ptr_q] = push_addr;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q   <= '{default: '0};
         addr_q   <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         data_q   <= data_d;
         addr_q   <= addr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign valid     = (count_q != 2'd0);
   assign count     = count_q;
   assign head_data = data_q[rd_ptr_q];
   assign head_addr = addr_q[rd_ptr_q];

endmodule

// File: rtl/conv_pe_seq.sv
// Sequencer that streams 3x3 valid-convolution windows through an external PE
// and buffers the results, at most two windows outstanding between PE and consumer.
module conv_pe_seq
   import cnn_pkg::*;
#(
   parameter int IFM_W  = 28,
   parameter int IFM_H  = 28,
   parameter int ADDR_W = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     ifm_rd_en,
   output logic        [ADDR_W-1:0] ifm_addr,
   input  logic signed [DATA_W-1:0] ifm_rd_data,
   output logic        [3:0]        w_addr,
   input  logic signed [DATA_W-1:0] w_rd_data,
   output logic                     pe_start,
   output logic                     pe_ready_in,
   output logic signed [DATA_W-1:0] pe_featuremap,
   output logic signed [DATA_W-1:0] pe_weight,
   input  logic signed [DATA_W-1:0] pe_result,
   input  logic                     pe_flag,
   conv_pe_seq_if.master            out_if
);

   localparam int OUT_W = IFM_W - KDIM + 1;
   localparam int OUT_H = IFM_H - KDIM + 1;
   localparam logic [3:0]        LAST_TAP = 4'(KERNEL_SIZE - 1);
   localparam logic [3:0]        KDIM_T   = 4'(KDIM);
   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(OUT_W - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(OUT_H - 1);
   localparam logic [ADDR_W-1:0] IFM_W_A  = ADDR_W'(IFM_W);

   seq_state_e        state_q, state_d;
   logic [3:0]        tap_q, tap_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic [ADDR_W-1:0] tag_q, tag_d;
   logic [1:0]        inflight_q, inflight_d;
   logic              rd_en_q, rd_en_d;

   logic              credit_ok, issue, win_start, last_issue, flag_ok;
   logic [ADDR_W-1:0] kr, kc, tap_addr;
   logic [1:0]        fifo_count;
   logic              fifo_valid, fifo_pop;
   logic signed [DATA_W-1:0] fifo_data;
   logic [ADDR_W-1:0] fifo_addr;

   // Credits are only checked on tap 0, so a window once begun always runs its nine taps.
   always_comb begin
      credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight_q}) < 3'd2;
      issue      = (state_q == RUN) && ((tap_q != 4'd0) || credit_ok);
      win_start  = issue && (tap_q == 4'd0);
      last_issue = issue && (tap_q == LAST_TAP) && (col_q == LAST_COL) && (row_q == LAST_ROW);
      flag_ok    = pe_flag && (inflight_q != 2'd0);
      kr         = ADDR_W'(tap_q / KDIM_T);
      kc         = ADDR_W'(tap_q % KDIM_T);
      tap_addr   = (row_q + kr) * IFM_W_A + col_q + kc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_issue) state_d = DRAIN;
         DRAIN:   if ((fifo_count == 2'd0) && (inflight_q == 2'd0)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy          = (state_q != IDLE);
      done          = (state_q == DONE);
      pe_start      = (state_q == RUN) || (state_q == DRAIN);
      ifm_rd_en     = issue;
      ifm_addr      = issue ? tap_addr : '0;
      w_addr        = issue ? tap_q : 4'd0;
      pe_ready_in   = rd_en_q;
      pe_featuremap = rd_en_q ? ifm_rd_data : '0;
      pe_weight     = rd_en_q ? w_rd_data : '0;
   end

   // Results return in issue order, so a running count is the index of the next window to land.
   always_comb begin
      tap_d      = tap_q;
      col_d      = col_q;
      row_d      = row_q;
      tag_d      = tag_q;
      inflight_d = inflight_q;
      rd_en_d    = issue;
      if ((state_q == IDLE) && start) begin
         tap_d = 4'd0;
         col_d = '0;
         row_d = '0;
         tag_d = '0;
      end
      if (issue) begin
         if (tap_q == LAST_TAP) begin
            tap_d = 4'd0;
            if (col_q == LAST_COL) begin
               col_d = '0;
               row_d = row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end else begin
            tap_d = tap_q + 4'd1;
         end
      end
      if (flag_ok) begin
         tag_d = tag_q + 1'b1;
      end
      case ({win_start, flag_ok})
         2'b10:   inflight_d = inflight_q + 2'd1;
         2'b01:   inflight_d = inflight_q - 2'd1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tap_q      <= 4'd0;
         col_q      <= '0;
         row_q      <= '0;
         tag_q      <= '0;
         inflight_q <= 2'd0;
         rd_en_q    <= 1'b0;
      end else begin
         tap_q      <= tap_d;
         col_q      <= col_d;
         row_q      <= row_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
         rd_en_q    <= rd_en_d;
      end
   end

   assign fifo_pop = fifo_valid && out_if.out_ready;

   conv_out_fifo #(
      .ADDR_W (ADDR_W)
   ) u_out_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (flag_ok),
      .push_data (pe_result),
      .push_addr (tag_q),
      .pop       (fifo_pop),
      .valid     (fifo_valid),
      .count     (fifo_count),
      .head_data (fifo_data),
      .head_addr (fifo_addr)
   );

   assign out_if.out_valid = fifo_valid;
   assign out_if.out_data  = fifo_data;
   assign out_if.out_addr  = fifo_addr;

endmodule
